// File: rtl/serial_bit_comparator_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_comparator_if
// Description : Control, bit-stream and result bundle for serial_bit_comparator.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_bit_comparator_if;
    logic start;
    logic sig;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic bit_ready;
    logic busy;
    logic done;
    logic lg;
    logic eq;
    logic ls;

    modport master (
        output start, sig, bit_valid, a_bit, b_bit,
        input  bit_ready, busy, done, lg, eq, ls
    );

    modport slave (
        input  start, sig, bit_valid, a_bit, b_bit,
        output bit_ready, busy, done, lg, eq, ls
    );
endinterface
`default_nettype wire

// File: rtl/serial_bit_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_comparator
// Description : MSB-first bit-serial signed/unsigned magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bit_comparator #(
    parameter int WIDTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    serial_bit_comparator_if.slave bus
);
    localparam int                 CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sig_q, sig_d;
    logic               decided_q, decided_d;
    logic               a_gt_q, a_gt_d;
    logic               msb_diff_q, msb_diff_d;
    logic               lg_q, lg_d;
    logic               eq_q, eq_d;
    logic               ls_q, ls_d;
    logic               w_beat;

    assign w_beat = (state_q == SHIFT) && bus.bit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sig_q      <= 1'b0;
            decided_q  <= 1'b0;
            a_gt_q     <= 1'b0;
            msb_diff_q <= 1'b0;
            lg_q       <= 1'b0;
            eq_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sig_q      <= sig_d;
            decided_q  <= decided_d;
            a_gt_q     <= a_gt_d;
            msb_diff_q <= msb_diff_d;
            lg_q       <= lg_d;
            eq_q       <= eq_d;
            ls_q       <= ls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sig_d      = sig_q;
        decided_d  = decided_q;
        a_gt_d     = a_gt_q;
        msb_diff_d = msb_diff_q;
        lg_d       = lg_q;
        eq_d       = eq_q;
        ls_d       = ls_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SHIFT;
                    cnt_d      = CNT_MAX;
                    sig_d      = bus.sig;
                    decided_d  = 1'b0;
                    a_gt_d     = 1'b0;
                    msb_diff_d = 1'b0;
                end
            end
            SHIFT: begin
                if (w_beat) begin
                    if (cnt_q == CNT_MAX) begin
                        msb_diff_d = bus.a_bit ^ bus.b_bit;
                    end
                    // The first differing bit (MSB first) settles the magnitude order.
                    if (!decided_q && (bus.a_bit != bus.b_bit)) begin
                        decided_d = 1'b1;
                        a_gt_d    = bus.a_bit;
                    end
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        // Signed operands with differing sign bits invert the unsigned order.
                        eq_d = ~decided_d;
                        lg_d = decided_d &  (a_gt_d ^ (sig_q & msb_diff_d));
                        ls_d = decided_d & ~(a_gt_d ^ (sig_q & msb_diff_d));
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.bit_ready = (state_q == SHIFT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.lg        = lg_q;
    assign bus.eq        = eq_q;
    assign bus.ls        = ls_q;

endmodule
`default_nettype wire
